// File: rtl/paced_fifo_drain.sv
// paced_fifo_drain
//   Synchronous FIFO with a full-rate write side and a read side paced by
//   a slow strobe (the divide-by-6 clk_6 from the clock divider). The
//   strobe is an ordinary clk-domain data signal. Each rising edge of
//   pace_in pops one word.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   pace_in    pace strobe; each rising edge requests one pop
//   wr_en      write request
//   wr_data    word to write
//   clr_flags  clears the sticky overflow/underflow flags
//   full       FIFO holds DEPTH words
//   empty      FIFO holds no words
//   count      occupancy, 0..DEPTH
//   out_valid  one-cycle pulse: out_data was updated this cycle
//   out_data   last popped word, held between pops
//   overflow   sticky: a write was attempted while full
//   underflow  sticky: a pace tick arrived while empty

module paced_fifo_drain #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pace_in,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_flags,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              overflow,
  output logic              underflow
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] wr_ptr_next;
  logic [ADDR_W:0] rd_ptr_next;

  logic pace_q;
  logic tick;
  logic do_write;
  logic do_pop;

  // full and empty are registered, so both decisions use the state from the
  // start of the cycle. A write into an empty FIFO therefore never falls
  // through to a same-cycle tick, and a write into a full FIFO is rejected
  // even if a pop frees a slot in that same cycle.
  assign tick     = pace_in & ~pace_q;
  assign do_write = wr_en & ~full;
  assign do_pop   = tick & ~empty;

  assign wr_ptr_next = wr_ptr + {{ADDR_W{1'b0}}, do_write};
  assign rd_ptr_next = rd_ptr + {{ADDR_W{1'b0}}, do_pop};

  // Storage is deliberately left out of reset. Words left behind are
  // unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  // pace_q resets high. A strobe that is already high when reset is
  // released is not treated as an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      count     <= '0;
      pace_q    <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      empty     <= (wr_ptr_next == rd_ptr_next);
      full      <= (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]) &&
                   (wr_ptr_next[ADDR_W] != rd_ptr_next[ADDR_W]);
      count     <= wr_ptr_next - rd_ptr_next;
      pace_q    <= pace_in;
      out_valid <= do_pop;
      if (do_pop) begin
        out_data <= mem[rd_ptr[ADDR_W-1:0]];
      end
      // A new flag event in the same cycle as clr_flags keeps the flag set.
      overflow  <= (overflow & ~clr_flags) | (wr_en & full);
      underflow <= (underflow & ~clr_flags) | (tick & empty);
    end
  end

endmodule

// File: tb/tb_paced_fifo_drain.sv
// tb_paced_fifo_drain
//   Directed and random stimulus for paced_fifo_drain. The expected
//   behaviour comes from a queue-based reference model that holds the
//   stored words, the previous pace level and the sticky flags.

module tb_paced_fifo_drain;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              reset;
  logic              pace_in;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              clr_flags;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              overflow;
  logic              underflow;

  paced_fifo_drain #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pace_in  (pace_in),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_flags(clr_flags),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .out_valid(out_valid),
    .out_data (out_data),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int phase  = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic              m_prev_pace;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ov;
  logic              m_uf;

  task automatic model_reset();
    q.delete();
    m_prev_pace = 1'b1;
    m_valid     = 1'b0;
    m_data      = '0;
    m_ov        = 1'b0;
    m_uf        = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("count",     32'(count),     32'(q.size()));
    check("empty",     32'(empty),     32'(q.size() == 0));
    check("full",      32'(full),      32'(q.size() == DEPTH));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("overflow",  32'(overflow),  32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_uf));
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, then
  // compare just after the edge.
  task automatic apply_stimulus(input logic p, input logic w,
                                input logic [DATA_W-1:0] d, input logic c);
    logic was_empty;
    logic was_full;
    logic tick;
    pace_in   = p;
    wr_en     = w;
    wr_data   = d;
    clr_flags = c;
    @(posedge clk);
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    tick      = p && !m_prev_pace;
    m_valid   = 1'b0;
    if (tick && !was_empty) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end
    if (w && !was_full) q.push_back(d);
    m_ov = (m_ov && !c) || (w && was_full);
    m_uf = (m_uf && !c) || (tick && was_empty);
    m_prev_pace = p;
    #1;
    check_output();
  endtask

  // Divider-shaped pace: 3 cycles high, 3 low.
  task automatic pace_step(input logic w, input logic [DATA_W-1:0] d,
                           input logic c);
    apply_stimulus(phase < 3, w, d, c);
    phase = (phase + 1) % 6;
  endtask

  // Reset is asserted between edges. The outputs must clear without
  // waiting for a clock edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_output();
    @(posedge clk);
    #1;
    check_output();
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    pace_in   = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    clr_flags = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output();
    reset = 1'b1;

    $display("[TB] pacing an empty FIFO");
    phase = 0;
    for (int i = 0; i < 24; i++) pace_step(1'b0, '0, 1'b0);

    $display("[TB] three writes then paced drain");
    apply_stimulus(1'b0, 1'b1, 8'h11, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h22, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h33, 1'b0);
    phase = 0;
    for (int i = 0; i < 24; i++) pace_step(1'b0, '0, 1'b0);

    $display("[TB] seventeen writes, overflow, drain across wrap");
    apply_stimulus(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 15) check("full_after_16", 32'(full), 32'd1);
    end
    check("overflow_after_17", 32'(overflow), 32'd1);
    phase = 0;
    for (int i = 0; i < 17 * 6; i++) pace_step(1'b0, '0, 1'b0);

    $display("[TB] tick and write on a full FIFO");
    apply_stimulus(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    apply_stimulus(1'b1, 1'b1, 8'hA5, 1'b0);
    check("count_after_pop", 32'(count), 32'd15);
    apply_stimulus(1'b1, 1'b1, 8'h5A, 1'b0);
    check("count_after_refill", 32'(count), 32'd16);
    phase = 3;
    for (int i = 0; i < 17 * 6; i++) pace_step(1'b0, '0, 1'b0);

    $display("[TB] clear versus new underflow");
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1);

    $display("[TB] reset mid-stream with pace high");
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
    check("count_before_reset", 32'(count), 32'd5);
    async_reset();
    apply_stimulus(1'b1, 1'b1, 8'h77, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);

    $display("[TB] random traffic, divider pace");
    phase = 0;
    for (int i = 0; i < 600; i++) begin
      pace_step($urandom_range(0, 99) < 25, 8'($urandom),
                $urandom_range(0, 39) == 0);
    end

    $display("[TB] random traffic, irregular pace");
    for (int i = 0; i < 600; i++) begin
      apply_stimulus($urandom_range(0, 2) == 0, $urandom_range(0, 99) < 40,
                     8'($urandom), $urandom_range(0, 39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/paced_fifo_drain.md
Name: paced_fifo_drain

Overview:
- Synchronous FIFO whose read side is paced by the divide-by-6 strobe (clk_6) from the clock divider, consumed as a plain data signal in the clk domain.
- Upstream logic writes at full clk rate. The block emits one word per rising edge of the pace input, giving a fixed slow output rate.
- Sits directly downstream of the divider. Overflow and underflow are reported as sticky flags.

Parameters:
DATA_W, 8, data word width
DEPTH, 16, FIFO depth in words; must be a power of 2, minimum 4
ADDR_W, 4, log2(DEPTH)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous active-low reset
pace_in  input  1  pace strobe (clk_6), generated in clk domain, no synchroniser
wr_en  input  1  write request
wr_data  input  DATA_W  write word
clr_flags  input  1  clears both sticky flags
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
count  output  ADDR_W+1  current occupancy, 0..DEPTH
out_valid  output  1  one-cycle pulse: out_data updated this cycle
out_data  output  DATA_W  last popped word, held between pops
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: pace tick while empty

Behaviour:
- Reset (reset=0, async, applied immediately):
  - rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0.
  - out_valid=0, out_data=0, overflow=0, underflow=0.
  - pace_q=1, so a pace_in already high at reset release is not a tick.
  - Memory contents are not reset.
- Pointers are ADDR_W+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = equal low bits with differing MSB.
  - count = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- Tick detect: pace_q <= pace_in every cycle; tick = pace_in & ~pace_q.
  - One tick per pace_in rising edge, whatever the high time.
- Write: when wr_en=1 and full=0 at cycle start, mem[wr_ptr] <= wr_data and wr_ptr increments.
  - wr_en=1 while full=1: word dropped, pointers unchanged, overflow <= 1.
- Pop: when tick=1 and empty=0 at cycle start, out_data <= mem[rd_ptr], rd_ptr increments, and out_valid is 1 the next cycle.
  - Latency: pace_in rises in cycle N, out_valid=1 and new out_data in cycle N+1.
  - out_valid is exactly one cycle wide.
- tick=1 while empty=1: no pop, out_valid stays 0, out_data unchanged, underflow <= 1.
- No fall-through. A write and a tick in the same cycle on an empty FIFO counts as an underflow; the word is stored and popped on a later tick.
- Simultaneous write and pop:
  - Not full and not empty: both happen, count unchanged.
  - Full: the pop happens and the write is rejected (full is sampled at cycle start), so overflow is set.
- Flags: clr_flags=1 clears overflow and underflow. If clr_flags and a new flag event occur in the same cycle, set wins.
- full, empty and count are registered and reflect the pointers after the previous edge.
- Reset asserted mid-stream: all state returns to reset values within the same cycle and stored words are discarded. After release the first pop needs a fresh pace_in rising edge.

Test Plan:
- Reset, then drive pace_in from the divider (3 high, 3 low) with no writes -> every 6 cycles underflow=1, out_valid never 1, count=0, empty=1.
- Write 0x11,0x22,0x33 in 3 back-to-back cycles, then pace -> out_valid pulses spaced 6 cycles apart with out_data 0x11, 0x22, 0x33, each 1 cycle after a pace_in rise. Then empty=1.
- Write 17 words 0x00..0x10 back-to-back with no pace -> full=1 and count=16 after the 16th write; 0x10 dropped, overflow=1. Draining yields 0x00..0x0F in order across the pointer wrap.
- FIFO full and a tick coincident with wr_en -> one pop (count 15), write rejected, overflow=1. Next cycle a write succeeds (count 16).
- Pulse clr_flags while a tick arrives on an empty FIFO -> underflow stays 1. clr_flags alone on a later cycle -> both flags 0.
- Assert reset for 1 cycle with count=5 and pace_in=1 -> outputs go to reset values immediately. No pop on release until pace_in falls and rises again.
